// File: rtl/plot_pixel_feeder.sv
// Serpentine raster reader: walks the 1-bit frame BRAM and hands each pixel
// to the plotter over a valid/ready handshake, freezing BRAM writes while busy.
module plot_pixel_feeder #(
  parameter int H_PIXELS   = 106,
  parameter int V_PIXELS   = 80,
  parameter int ADDR_WIDTH = 14,
  parameter int READ_LAT   = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  enable_in,
  input  logic                  ready_next_pixel_in,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  input  logic                  bram_data_in,
  output logic                  pixel_value_out,
  output logic                  pixel_valid_out,
  output logic [6:0]            hcount_out,
  output logic [6:0]            vcount_out,
  output logic                  busy_out,
  output logic                  freeze_out,
  output logic                  done_out
);

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [6:0]    H_LAST   = 7'(H_PIXELS - 1);
  localparam logic [6:0]    V_LAST   = 7'(V_PIXELS - 1);
  localparam logic [CW-1:0] WAIT_END = CW'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [6:0]            h_q, h_d, v_q, v_d;
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  pixel_q, pixel_d;
  logic                  valid_q, valid_d;
  logic [6:0]            hcount_q, hcount_d, vcount_q, vcount_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic       row_end;
  logic       last_px;
  logic [6:0] h_adv, v_adv;

  // Next position along the serpentine path; rows end on alternating sides.
  always_comb begin
    row_end = v_q[0] ? (h_q == 7'd0) : (h_q == H_LAST);
    last_px = row_end && (v_q == V_LAST);
    h_adv   = h_q;
    v_adv   = v_q;
    if (row_end) begin
      v_adv = v_q + 7'd1;
    end else if (v_q[0]) begin
      h_adv = h_q - 7'd1;
    end else begin
      h_adv = h_q + 7'd1;
    end
  end

  // The address is loaded on entry to FETCH so it is already on the BRAM
  // port during FETCH; the read then lands exactly at the end of WAIT.
  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    v_d        = v_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    pixel_d    = pixel_q;
    valid_d    = valid_q;
    hcount_d   = hcount_q;
    vcount_d   = vcount_q;
    busy_d     = busy_q;
    done_d     = done_q;

    if (enable_in) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_in) begin
            h_d     = 7'd0;
            v_d     = 7'd0;
            addr_d  = '0;
            valid_d = 1'b0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_END) begin
            pixel_d  = bram_data_in;
            hcount_d = h_q;
            vcount_d = v_q;
            valid_d  = 1'b1;
            state_d  = S_PRESENT;
          end else begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
        end
        S_PRESENT: begin
          if (valid_q && ready_next_pixel_in) begin
            valid_d = 1'b0;
            if (last_px) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              h_d     = h_adv;
              v_d     = v_adv;
              addr_d  = ADDR_WIDTH'(int'(v_adv) * H_PIXELS + int'(h_adv));
              state_d = S_FETCH;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      h_q        <= '0;
      v_q        <= '0;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      pixel_q    <= 1'b0;
      valid_q    <= 1'b0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      pixel_q    <= pixel_d;
      valid_q    <= valid_d;
      hcount_q   <= hcount_d;
      vcount_q   <= vcount_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bram_addr_out   = addr_q;
  assign pixel_value_out = pixel_q;
  assign pixel_valid_out = valid_q;
  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign busy_out        = busy_q;
  assign freeze_out      = busy_q;
  assign done_out        = done_q;

endmodule

// File: tb/tb_plot_pixel_feeder.sv
// Directed bench for plot_pixel_feeder on a 4x3 frame with a 2-cycle BRAM model.
module tb_plot_pixel_feeder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        enable_in;
  logic        ready_next_pixel_in;
  logic [13:0] bram_addr_out;
  logic        bram_data_in;
  logic        pixel_value_out;
  logic        pixel_valid_out;
  logic [6:0]  hcount_out;
  logic [6:0]  vcount_out;
  logic        busy_out;
  logic        freeze_out;
  logic        done_out;

  int compared   = 0;
  int mismatched = 0;

  logic [11:0] mem_bits = 12'b1001_1101_0110;
  logic        bram_s1  = 1'b0;

  int exp_h[12]    = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3};
  int exp_v[12]    = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  int exp_addr[12] = '{0, 1, 2, 3, 7, 6, 5, 4, 8, 9, 10, 11};

  plot_pixel_feeder #(
    .H_PIXELS(4),
    .V_PIXELS(3),
    .ADDR_WIDTH(14),
    .READ_LAT(2)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .enable_in(enable_in),
    .ready_next_pixel_in(ready_next_pixel_in),
    .bram_addr_out(bram_addr_out),
    .bram_data_in(bram_data_in),
    .pixel_value_out(pixel_value_out),
    .pixel_valid_out(pixel_valid_out),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .busy_out(busy_out),
    .freeze_out(freeze_out),
    .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  initial bram_data_in = 1'b0;

  // Two-stage registered read: address sampled at one edge, data two edges on
  always @(posedge clk_in) begin
    bram_s1      <= (bram_addr_out < 14'd12) ? mem_bits[bram_addr_out[3:0]] : 1'b0;
    bram_data_in <= bram_s1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic enable, input logic ready);
    start_in            = start;
    enable_in           = enable;
    ready_next_pixel_in = ready;
  endtask

  task automatic pulseStart();
    start_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!pixel_valid_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput(tag, 32'(pixel_valid_out), 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(pixel_valid_out), 0);
    checkOutput({tag, "_value"}, 32'(pixel_value_out), 0);
    checkOutput({tag, "_h"}, 32'(hcount_out), 0);
    checkOutput({tag, "_v"}, 32'(vcount_out), 0);
    checkOutput({tag, "_addr"}, 32'(bram_addr_out), 0);
    checkOutput({tag, "_busy"}, 32'(busy_out), 0);
    checkOutput({tag, "_freeze"}, 32'(freeze_out), 0);
    checkOutput({tag, "_done"}, 32'(done_out), 0);
  endtask

  task automatic checkPixel(input int i);
    checkOutput($sformatf("px%0d_h", i), 32'(hcount_out), exp_h[i]);
    checkOutput($sformatf("px%0d_v", i), 32'(vcount_out), exp_v[i]);
    checkOutput($sformatf("px%0d_addr", i), 32'(bram_addr_out), exp_addr[i]);
    checkOutput($sformatf("px%0d_value", i), 32'(pixel_value_out), 32'(mem_bits[exp_addr[i]]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cycles;
    bit  held;
    logic first_value;

    rst_in = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk_in);
    checkAllZero("reset");
    rst_in = 1'b0;
    @(negedge clk_in);

    // Latency from start to first valid pixel, ready held low
    pulseStart();
    checkOutput("start_busy", 32'(busy_out), 1);
    checkOutput("start_freeze", 32'(freeze_out), 1);
    checkOutput("start_done", 32'(done_out), 0);
    checkOutput("start_addr", 32'(bram_addr_out), 0);
    cycles = 1;
    while (!pixel_valid_out && cycles < 20) begin
      @(negedge clk_in);
      cycles++;
    end
    checkOutput("latency", 32'(cycles), 4);
    first_value = pixel_value_out;
    held = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      if (!pixel_valid_out || pixel_value_out !== first_value) held = 1'b0;
    end
    checkOutput("first_stable", 32'(held), 1);

    // Full serpentine frame with backpressure, pause and ignored start
    for (int i = 0; i < 12; i++) begin
      waitValid($sformatf("px%0d_valid", i));
      checkPixel(i);
      if (i == 5) begin
        held = 1'b1;
        repeat (20) begin
          @(negedge clk_in);
          if (!pixel_valid_out || hcount_out != 7'd2 || vcount_out != 7'd1 ||
              pixel_value_out !== mem_bits[6]) held = 1'b0;
        end
        checkOutput("bp_hold", 32'(held), 1);
      end
      if (i == 6) begin
        repeat (3) @(negedge clk_in);
        checkOutput("one_pulse_valid", 32'(pixel_valid_out), 1);
        checkOutput("one_pulse_h", 32'(hcount_out), 1);
      end
      ready_next_pixel_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      checkOutput($sformatf("px%0d_consumed", i), 32'(pixel_valid_out), 0);
      if (i == 4 || i == 5) ready_next_pixel_in = 1'b0;
      if (i == 7) begin
        @(posedge clk_in);
        @(negedge clk_in);
        enable_in = 1'b0;
        held = 1'b1;
        repeat (10) begin
          @(negedge clk_in);
          if (pixel_valid_out || bram_addr_out != 14'd8) held = 1'b0;
        end
        checkOutput("pause_hold", 32'(held), 1);
        enable_in = 1'b1;
      end
      if (i == 9) begin
        pulseStart();
        checkOutput("midframe_busy", 32'(busy_out), 1);
        checkOutput("midframe_done", 32'(done_out), 0);
      end
    end

    checkOutput("end_done", 32'(done_out), 1);
    checkOutput("end_busy", 32'(busy_out), 0);
    checkOutput("end_freeze", 32'(freeze_out), 0);
    repeat (5) @(negedge clk_in);
    checkOutput("end_addr_hold", 32'(bram_addr_out), 11);
    checkOutput("end_valid", 32'(pixel_valid_out), 0);
    checkOutput("end_done_hold", 32'(done_out), 1);

    // Restart after DONE, then reset in the middle of pixel 7
    pulseStart();
    checkOutput("restart_done", 32'(done_out), 0);
    checkOutput("restart_busy", 32'(busy_out), 1);
    checkOutput("restart_addr", 32'(bram_addr_out), 0);
    for (int i = 0; i < 8; i++) begin
      waitValid($sformatf("rerun%0d_valid", i));
      checkOutput($sformatf("rerun%0d_h", i), 32'(hcount_out), exp_h[i]);
      checkOutput($sformatf("rerun%0d_v", i), 32'(vcount_out), exp_v[i]);
      if (i < 7) begin
        @(posedge clk_in);
        @(negedge clk_in);
      end
    end
    rst_in = 1'b1;
    #1;
    checkAllZero("async_rst");
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    ready_next_pixel_in = 1'b0;
    pulseStart();
    waitValid("post_rst_valid");
    checkPixel(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
